// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// Frame: start, data LSB first, XOR parity, stop.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int MAX_WIDTH = 64;

    // Callers zero-extend narrower words; the extra zeros do not change XOR.
    function automatic logic calc_parity(
        input logic [MAX_WIDTH-1:0] word,
        input logic                 odd
    );
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period cycle counter; ticks on the last cycle of each bit.
// Held at zero while run is low.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter with valid/ready input.
// txd and busy are registered from the next-state decode.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             txd,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             run;

    assign run       = (state_q != IDLE);
    assign din_ready = (state_q == IDLE);
    assign txd       = txd_q;
    assign busy      = busy_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d  = START;
                    shift_d  = din;
                    bitcnt_d = '0;
                    par_d    = calc_parity(MAX_WIDTH'(din), PARITY_ODD);
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d  = IDLE;
                    bitcnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decoded from the state being entered so it is registered.
    always_comb begin
        txd_d  = LINE_IDLE;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            IDLE:    txd_d = LINE_IDLE;
            START:   txd_d = LINE_START;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            STOP:    txd_d = LINE_IDLE;
            default: txd_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            txd_q    <= LINE_IDLE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

endmodule
